// File: rtl/bram_master_pkg.sv
// Shared types and constants for the BRAM port master.
// BRAM_OUTREG_EN selects the BRAM's extra output register (read latency 2 instead of 1).
package bram_master_pkg;

  localparam int BRAM_ADDR_W = 16;
  localparam int BRAM_DATA_W = 32;
  localparam int BRAM_BE_W   = BRAM_DATA_W / 8;

`ifdef BRAM_OUTREG_EN
  localparam int BRAM_LAT = 2;
`else
  localparam int BRAM_LAT = 1;
`endif

  typedef struct packed {
    logic [BRAM_ADDR_W-1:0] addr;
    logic                   we;
    logic [BRAM_BE_W-1:0]   be;
    logic [BRAM_DATA_W-1:0] wdata;
  } bram_req_t;

  typedef struct packed {
    logic [BRAM_DATA_W-1:0] rdata;
    logic                   write;
  } bram_rsp_t;

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Response FIFO of bram_rsp_t; any depth, pointers wrap modulo DEPTH.
// Head is driven from storage and forced to zero while empty.
module bram_rsp_fifo
  import bram_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  bram_rsp_t                  push_data,
  input  logic                       pop,
  output bram_rsp_t                  head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  bram_rsp_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt;
  logic           do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = empty ? '0 : mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && (cnt == CW'(DEPTH))));

endmodule

// File: rtl/bram_port_master.sv
// Initiator for one BRAM port: valid/ready requests in, in-order responses out via a credit-checked FIFO.
// Build with BRAM_OUTREG_EN when the BRAM has its extra output register (read latency 2).
module bram_port_master
  import bram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_write,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  input  logic [DATA_WIDTH-1:0]   bram_rdata
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int TW = CW + 2;

  // The shared structs fix the word geometry, so the ports must agree with them.
  generate
    if (RSP_DEPTH < BRAM_LAT + 1) begin : g_depth_chk
      $error("bram_port_master: RSP_DEPTH must be >= BRAM_LAT+1");
    end
    if (ADDR_WIDTH != BRAM_ADDR_W || DATA_WIDTH != BRAM_DATA_W) begin : g_width_chk
      $error("bram_port_master: widths must match bram_master_pkg");
    end
  endgenerate

  bram_req_t          req;
  bram_rsp_t          push_rsp, head;
  logic               ready_en;
  logic               accept;
  logic [BRAM_LAT:1]  vld_pipe, we_pipe;
  logic [CW-1:0]      fifo_count;
  logic [TW-1:0]      inflight, credit_used;
  logic               fifo_empty;

  assign req = '{addr: req_addr, we: req_we, be: req_be, wdata: req_wdata};

  // Credit uses registered terms only, so rsp_ready never reaches req_ready.
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= BRAM_LAT; i++) inflight += TW'(vld_pipe[i]);
  end

  assign credit_used = TW'(fifo_count) + inflight;
  assign req_ready   = ready_en && (credit_used < TW'(RSP_DEPTH));
  assign accept      = req_valid && req_ready;

  assign bram_en    = accept;
  assign bram_we    = (accept && req.we) ? req.be : '0;
  assign bram_addr  = req.addr;
  assign bram_wdata = req.wdata;

  // Holds off acceptance until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      we_pipe  <= '0;
    end else begin
      vld_pipe[1] <= accept;
      we_pipe[1]  <= accept && req.we;
      for (int i = 2; i <= BRAM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        we_pipe[i]  <= we_pipe[i-1];
      end
    end
  end

  assign push_rsp = '{rdata: bram_rdata, write: we_pipe[BRAM_LAT]};

  bram_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (vld_pipe[BRAM_LAT]),
    .push_data (push_rsp),
    .pop       (rsp_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = head.rdata;
  assign rsp_write = head.write;

endmodule
